// File: rtl/measure_count_window_if.sv
// measure_count_window_if: enable/increment inputs and windowed result outputs of measure_count_window.
// sample_bin exists only when MEASURE_COUNT_WINDOW_BINARY_EN is defined.
interface measure_count_window_if #(
   parameter int DIGITS = 9,
   parameter int INC_W  = 4
);
   logic                  en;
   logic                  valid;
   logic [INC_W-1:0]      inc;
   logic [4*DIGITS-1:0]   sample;
   logic                  sample_valid;
   logic                  overflow;
   logic                  busy;
`ifdef MEASURE_COUNT_WINDOW_BINARY_EN
   localparam int BIN_W = $clog2(64'd10 ** DIGITS);
   logic [BIN_W-1:0]      sample_bin;
   modport master (output en, valid, inc, input sample, sample_valid, overflow, busy, sample_bin);
   modport slave  (input en, valid, inc, output sample, sample_valid, overflow, busy, sample_bin);
`else
   modport master (output en, valid, inc, input sample, sample_valid, overflow, busy);
   modport slave  (input en, valid, inc, output sample, sample_valid, overflow, busy);
`endif
endinterface

// File: rtl/measure_count_window.sv
// measure_count_window: saturating BCD event counter sampled every WINDOW_CYCLES clocks while en is high.
// Defining MEASURE_COUNT_WINDOW_BINARY_EN adds a binary shadow result on bus.sample_bin.
module measure_count_window #(
   parameter int DIGITS        = 9,
   parameter int MAX_INC       = 4,
   parameter int INC_W         = 4,
   parameter int WINDOW_CYCLES = 100000000
) (
   input logic                   clk,
   input logic                   rst_n,
   measure_count_window_if.slave bus
);
   localparam int TW = $clog2(WINDOW_CYCLES);
   localparam logic [TW-1:0] LAST_T = TW'(WINDOW_CYCLES - 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t              state;
   logic [TW-1:0]       timer;
   logic [4*DIGITS-1:0] acc, sum_bcd, sum_sat;
   logic                sticky, ov, last, keep;
   logic [3:0]          eff;
   logic [4:0]          c, d;
   assign eff = !bus.valid ? 4'd0 : (bus.inc > INC_W'(MAX_INC)) ? 4'(MAX_INC) : 4'(bus.inc);
   // Decimal carry ripples through every digit within the same cycle.
   always_comb begin
      sum_bcd = '0;
      c = {1'b0, eff};
      d = '0;
      for (int k = 0; k < DIGITS; k++) begin
         d = {1'b0, acc[4*k +: 4]} + c;
         sum_bcd[4*k +: 4] = d > 5'd9 ? 4'(d - 5'd10) : d[3:0];
         c = {4'd0, d > 5'd9};
      end
      ov = c[0];
   end
   assign sum_sat = ov ? {DIGITS{4'h9}} : sum_bcd;
   assign last = state == RUN && bus.en && timer == LAST_T;
   assign keep = state == RUN && bus.en && !last;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         timer            <= '0;
         acc              <= '0;
         sticky           <= 1'b0;
         bus.sample       <= '0;
         bus.sample_valid <= 1'b0;
         bus.overflow     <= 1'b0;
         bus.busy         <= 1'b0;
      end else begin
         state            <= bus.en ? RUN : IDLE;
         bus.busy         <= bus.en;
         bus.sample_valid <= last;
         acc              <= keep ? sum_sat : '0;
         sticky           <= keep && (sticky || ov);
         timer            <= keep ? timer + 1'b1 : '0;
         if (last) begin
            bus.sample   <= sum_sat;
            bus.overflow <= sticky || ov;
         end
      end
   end
`ifdef MEASURE_COUNT_WINDOW_BINARY_EN
   localparam logic [63:0] MAXV = 64'd10 ** DIGITS - 64'd1;
   localparam int BW = $clog2(MAXV + 64'd1);
   logic [BW-1:0] bin_acc, bin_sat;
   logic [BW:0]   bin_sum;
   assign bin_sum = {1'b0, bin_acc} + (BW+1)'(eff);
   assign bin_sat = bin_sum > (BW+1)'(MAXV) ? BW'(MAXV) : bin_sum[BW-1:0];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_acc        <= '0;
         bus.sample_bin <= '0;
      end else begin
         bin_acc <= keep ? bin_sat : '0;
         if (last) bus.sample_bin <= bin_sat;
      end
   end
`endif
endmodule

// File: tb/tb_measure_count_window.sv
// tb_measure_count_window: three window lengths (16, 25, 300) share one stimulus stream and are
// compared every cycle against an integer-count reference model.
module tb_measure_count_window;
   localparam int WIN[3] = '{16, 25, 300};
   logic clk = 1'b0, rst_n = 1'b0;
   logic en = 1'b0, valid = 1'b0;
   logic [3:0] inc = '0;
   int total = 0, bad = 0;
   int m_cnt[3], m_t[3], m_samp[3];
   bit m_run[3], m_ov[3], m_sv[3];
   logic [11:0] o_sample[3];
   logic o_sv[3], o_ov[3], o_busy[3];
   always #5 clk = ~clk;
   measure_count_window_if #(.DIGITS(3), .INC_W(4)) b0 ();
   measure_count_window_if #(.DIGITS(3), .INC_W(4)) b1 ();
   measure_count_window_if #(.DIGITS(3), .INC_W(4)) b2 ();
   measure_count_window #(.DIGITS(3), .MAX_INC(4), .INC_W(4), .WINDOW_CYCLES(16))
      u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
   measure_count_window #(.DIGITS(3), .MAX_INC(4), .INC_W(4), .WINDOW_CYCLES(25))
      u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
   measure_count_window #(.DIGITS(3), .MAX_INC(4), .INC_W(4), .WINDOW_CYCLES(300))
      u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
   assign b0.en = en;
   assign b0.valid = valid;
   assign b0.inc = inc;
   assign b1.en = en;
   assign b1.valid = valid;
   assign b1.inc = inc;
   assign b2.en = en;
   assign b2.valid = valid;
   assign b2.inc = inc;
   assign o_sample[0] = b0.sample;
   assign o_sample[1] = b1.sample;
   assign o_sample[2] = b2.sample;
   assign o_sv[0] = b0.sample_valid;
   assign o_sv[1] = b1.sample_valid;
   assign o_sv[2] = b2.sample_valid;
   assign o_ov[0] = b0.overflow;
   assign o_ov[1] = b1.overflow;
   assign o_ov[2] = b2.overflow;
   assign o_busy[0] = b0.busy;
   assign o_busy[1] = b1.busy;
   assign o_busy[2] = b2.busy;
`ifdef MEASURE_COUNT_WINDOW_BINARY_EN
   logic [9:0] o_bin[3];
   assign o_bin[0] = b0.sample_bin;
   assign o_bin[1] = b1.sample_bin;
   assign o_bin[2] = b2.sample_bin;
`endif

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0; m_t[i] = 0; m_samp[i] = 0;
         m_run[i] = 0; m_ov[i] = 0; m_sv[i] = 0;
      end
   endtask

   // Count is kept unbounded; saturation is applied only when a window closes.
   task automatic model_edge();
      int e;
      e = valid ? (inc > 4 ? 4 : int'(inc)) : 0;
      for (int i = 0; i < 3; i++) begin
         m_sv[i] = 0;
         if (!m_run[i] || !en) begin
            m_cnt[i] = 0;
            m_t[i] = 0;
            m_run[i] = en;
         end else begin
            m_cnt[i] += e;
            if (m_t[i] == WIN[i] - 1) begin
               m_samp[i] = m_cnt[i] > 999 ? 999 : m_cnt[i];
               m_ov[i] = m_cnt[i] > 999;
               m_sv[i] = 1;
               m_cnt[i] = 0;
               m_t[i] = 0;
            end else m_t[i]++;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d.sample", i), 64'(o_sample[i]), 64'(to_bcd(m_samp[i])));
         chk($sformatf("u%0d.sample_valid", i), 64'(o_sv[i]), 64'(m_sv[i]));
         chk($sformatf("u%0d.overflow", i), 64'(o_ov[i]), 64'(m_ov[i]));
         chk($sformatf("u%0d.busy", i), 64'(o_busy[i]), 64'(m_run[i]));
`ifdef MEASURE_COUNT_WINDOW_BINARY_EN
         chk($sformatf("u%0d.sample_bin", i), 64'(o_bin[i]), 64'(m_samp[i]));
`endif
      end
   endtask

   task automatic run(input int n, input bit e_, input bit v_, input int i_);
      for (int k = 0; k < n; k++) begin
         en = e_;
         valid = v_;
         inc = 4'(i_);
         @(posedge clk);
         model_edge();
         #1;
         check_all();
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      run(33, 1, 1, 2);
      chk("basic_sample", 64'(o_sample[0]), 64'h032);
      chk("basic_pulse", 64'(o_sv[0]), 64'd1);
      run(1, 0, 1, 2);
      run(26, 1, 1, 4);
      chk("carry_sample", 64'(o_sample[1]), 64'h100);
      run(1, 0, 1, 4);
      run(17, 1, 1, 7);
      chk("clamp_sample", 64'(o_sample[0]), 64'h064);
      run(11, 1, 1, 3);
      run(1, 0, 1, 3);
      chk("abort_keep", 64'(o_sample[0]), 64'h064);
      chk("abort_busy", 64'(o_busy[0]), 64'd0);
      run(17, 1, 1, 3);
      chk("reenable_sample", 64'(o_sample[0]), 64'h048);
      run(16, 1, 0, 4);
      chk("gated_sample", 64'(o_sample[0]), 64'h000);
      chk("gated_ovf", 64'(o_ov[0]), 64'd0);
      run(1, 0, 1, 4);
      run(301, 1, 1, 4);
      chk("sat_sample", 64'(o_sample[2]), 64'h999);
      chk("sat_ovf", 64'(o_ov[2]), 64'd1);
      run(300, 1, 1, 1);
      chk("post_sat_sample", 64'(o_sample[2]), 64'h300);
      chk("post_sat_ovf", 64'(o_ov[2]), 64'd0);
      for (int k = 0; k < 500; k++)
         run(1, $urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)));
      run(1, 0, 1, 2);
      run(17, 1, 1, 2);
      run(5, 1, 1, 3);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_sample", 64'(o_sample[0]), 64'd0);
      chk("async_busy", 64'(o_busy[0]), 64'd0);
      chk("async_ovf", 64'(o_ov[2]), 64'd0);
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      run(20, 1, 1, 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
